// File: rtl/flag_change_pkg.sv
// Shared constants and types for the flag change-capture FIFO.
// The FIFO entry is the {multi, flags} snapshot taken when the snapshot changes.
package flag_change_pkg;

  localparam int WIDTH_DEFAULT = 10;
  localparam int DEPTH_DEFAULT = 4;
  localparam int FLAG_W        = 7;
  localparam int MULTI_W       = 3;
  localparam int CNT_W         = 8;

  localparam logic [CNT_W-1:0] CNT_MAX = 8'd255;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO with a separate occupancy counter.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module sync_fifo_fwft #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] data,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  logic w_push;
  logic w_pop;

  assign empty  = (r_count == '0);
  assign full   = (r_count == (AW+1)'(DEPTH));
  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage is deliberately left unreset; the empty mask on data hides stale words.
  always_ff @(posedge CLK) begin
    if (w_push && !RST) r_mem[r_wr_ptr] <= push_data;
  end

  assign data = empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/flag_change_fifo.sv
// Captures every change of the {MULTI_IN, FLAGS_IN} snapshot into a FWFT FIFO,
// with a sticky overflow flag and a saturating change counter.
module flag_change_fifo
  import flag_change_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [FLAG_W-1:0]  FLAGS_IN,
  input  logic [MULTI_W-1:0] MULTI_IN,
  output logic [WIDTH-1:0]   OUT_DATA,
  output logic               OUT_VALID,
  input  logic               OUT_READY,
  output logic               OVERFLOW,
  output logic [CNT_W-1:0]   CHANGE_CNT
);

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_prev;
  logic             r_overflow;
  logic [CNT_W-1:0] r_change_cnt;

  logic [WIDTH-1:0] w_snap;
  logic [WIDTH-1:0] w_fifo_data;
  logic             w_change;
  logic             w_push;
  logic             w_drop;
  logic             w_pop;
  logic             w_empty;
  logic             w_full;

  assign w_snap = {MULTI_IN, FLAGS_IN};
  assign w_pop  = OUT_READY && !w_empty;

  always_ff @(posedge CLK) begin
    if (RST) r_state <= INIT;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (r_state == INIT) w_next_state = RUN;
  end

  // NOTE: every signal written here gets a default first so no latch can be inferred.
  always_comb begin
    w_change = 1'b0;
    w_push   = 1'b0;
    w_drop   = 1'b0;
    if (r_state == RUN && w_snap != r_prev) begin
      w_change = 1'b1;
      w_push   = !w_full || w_pop;
      w_drop   = w_full && !w_pop;
    end
  end

  // PREV tracks the snapshot every cycle, including INIT, so INIT only primes it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_prev       <= '0;
      r_overflow   <= 1'b0;
      r_change_cnt <= '0;
    end else begin
      r_prev <= w_snap;
      if (w_drop) r_overflow <= 1'b1;
      if (w_change && r_change_cnt != CNT_MAX) r_change_cnt <= r_change_cnt + CNT_W'(1);
    end
  end

  sync_fifo_fwft #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .push      (w_push),
    .push_data (w_snap),
    .pop       (w_pop),
    .data      (w_fifo_data),
    .empty     (w_empty),
    .full      (w_full)
  );

  assign OUT_DATA   = w_fifo_data;
  assign OUT_VALID  = !w_empty;
  assign OVERFLOW   = r_overflow;
  assign CHANGE_CNT = r_change_cnt;

endmodule

// File: tb/tb_flag_change_fifo.sv
// Directed bench for flag_change_fifo: priming, overflow, full push/pop, wrap,
// mid-operation reset and counter saturation, with hand-computed expectations.
module tb_flag_change_fifo;
  import flag_change_pkg::*;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic [6:0]   FLAGS_IN = '0;
  logic [2:0]   MULTI_IN = '0;
  logic [9:0]   OUT_DATA;
  logic         OUT_VALID;
  logic         OUT_READY = 1'b0;
  logic         OVERFLOW;
  logic [7:0]   CHANGE_CNT;

  int n_checks = 0;
  int n_fail   = 0;

  flag_change_fifo dut (
    .CLK        (CLK),
    .RST        (RST),
    .FLAGS_IN   (FLAGS_IN),
    .MULTI_IN   (MULTI_IN),
    .OUT_DATA   (OUT_DATA),
    .OUT_VALID  (OUT_VALID),
    .OUT_READY  (OUT_READY),
    .OVERFLOW   (OVERFLOW),
    .CHANGE_CNT (CHANGE_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the active edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_s(input logic [9:0] v);
    {MULTI_IN, FLAGS_IN} = v;
  endtask

  task automatic reset_dut();
    RST = 1'b1;
    step();
    RST = 1'b0;
    step();
  endtask

  task automatic pop_check(input string tag, input logic [9:0] exp);
    check({tag, "_valid"}, 32'(OUT_VALID), 32'd1);
    check({tag, "_data"}, 32'(OUT_DATA), 32'(exp));
    OUT_READY = 1'b1;
    step();
    OUT_READY = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [9:0] s;

    // Priming: reset edge and INIT edge both see S = 0, then S = 0x005.
    set_s(10'h000);
    step();
    check("rst_valid", 32'(OUT_VALID), 32'd0);
    check("rst_data", 32'(OUT_DATA), 32'd0);
    check("rst_ovf", 32'(OVERFLOW), 32'd0);
    check("rst_cnt", 32'(CHANGE_CNT), 32'd0);
    check("rst_state", 32'(dut.r_state), 32'(INIT));
    RST = 1'b0;
    step();
    check("init_state", 32'(dut.r_state), 32'(RUN));
    check("init_valid", 32'(OUT_VALID), 32'd0);
    set_s(10'h005);
    step();
    check("prime_valid", 32'(OUT_VALID), 32'd1);
    check("prime_data", 32'(OUT_DATA), 32'h005);
    check("prime_cnt", 32'(CHANGE_CNT), 32'd1);
    repeat (4) step();
    check("prime_cnt_hold", 32'(CHANGE_CNT), 32'd1);
    check("prime_occ", 32'(dut.u_fifo.r_count), 32'd1);
    pop_check("prime_pop", 10'h005);
    check("prime_empty_valid", 32'(OUT_VALID), 32'd0);
    check("prime_empty_data", 32'(OUT_DATA), 32'd0);

    // Fill and overflow: INIT must not push the held 0x005.
    reset_dut();
    check("fill_init_nopush", 32'(OUT_VALID), 32'd0);
    s = 10'h005;
    for (int i = 1; i <= 6; i++) begin
      s[0] = ~s[0];
      set_s(s);
      step();
      check("fill_valid", 32'(OUT_VALID), 32'd1);
      if (i == 4) check("fill_ovf_at4", 32'(OVERFLOW), 32'd0);
      if (i == 5) check("fill_ovf_at5", 32'(OVERFLOW), 32'd1);
    end
    check("fill_cnt", 32'(CHANGE_CNT), 32'd6);
    check("fill_occ", 32'(dut.u_fifo.r_count), 32'd4);
    pop_check("fill_e0", 10'h004);
    pop_check("fill_e1", 10'h005);
    pop_check("fill_e2", 10'h004);
    pop_check("fill_e3", 10'h005);
    check("fill_drained", 32'(OUT_VALID), 32'd0);
    check("fill_ovf_sticky", 32'(OVERFLOW), 32'd1);

    // Full with simultaneous push and pop.
    set_s(10'h000);
    reset_dut();
    set_s(10'h011); step();
    set_s(10'h022); step();
    set_s(10'h033); step();
    set_s(10'h044); step();
    check("full_occ", 32'(dut.u_fifo.r_count), 32'd4);
    OUT_READY = 1'b1;
    set_s(10'h055);
    step();
    OUT_READY = 1'b0;
    check("pp_occ", 32'(dut.u_fifo.r_count), 32'd4);
    check("pp_ovf", 32'(OVERFLOW), 32'd0);
    check("pp_cnt", 32'(CHANGE_CNT), 32'd5);
    pop_check("pp_e0", 10'h022);
    pop_check("pp_e1", 10'h033);
    pop_check("pp_e2", 10'h044);
    pop_check("pp_e3", 10'h055);

    // Pop while empty is ignored, then drain across the pointer wrap.
    OUT_READY = 1'b1;
    step();
    OUT_READY = 1'b0;
    check("empty_pop_valid", 32'(OUT_VALID), 32'd0);
    check("empty_pop_occ", 32'(dut.u_fifo.r_count), 32'd0);
    set_s(10'h101); step();
    set_s(10'h202); step();
    set_s(10'h303); step();
    pop_check("wrap_e0", 10'h101);
    pop_check("wrap_e1", 10'h202);
    set_s(10'h3FF); step();
    set_s(10'h000); step();
    set_s(10'h155); step();
    check("wrap_occ", 32'(dut.u_fifo.r_count), 32'd4);
    pop_check("wrap_e2", 10'h303);
    pop_check("wrap_e3", 10'h3FF);
    pop_check("wrap_e4", 10'h000);
    pop_check("wrap_e5", 10'h155);
    check("wrap_empty_valid", 32'(OUT_VALID), 32'd0);
    check("wrap_empty_data", 32'(OUT_DATA), 32'd0);

    // Reset mid-operation with 3 entries held and OVERFLOW set.
    set_s(10'h001); step();
    set_s(10'h002); step();
    set_s(10'h003); step();
    set_s(10'h004); step();
    set_s(10'h005); step();
    check("mid_ovf_set", 32'(OVERFLOW), 32'd1);
    pop_check("mid_head", 10'h001);
    check("mid_occ", 32'(dut.u_fifo.r_count), 32'd3);
    RST = 1'b1;
    OUT_READY = 1'b1;
    set_s(10'h006);
    step();
    check("mid_rst_valid", 32'(OUT_VALID), 32'd0);
    check("mid_rst_data", 32'(OUT_DATA), 32'd0);
    check("mid_rst_ovf", 32'(OVERFLOW), 32'd0);
    check("mid_rst_cnt", 32'(CHANGE_CNT), 32'd0);
    check("mid_rst_state", 32'(dut.r_state), 32'(INIT));
    check("mid_rst_occ", 32'(dut.u_fifo.r_count), 32'd0);
    RST = 1'b0;
    step();
    check("mid_init_valid", 32'(OUT_VALID), 32'd0);
    check("mid_init_state", 32'(dut.r_state), 32'(RUN));

    // Saturation: 300 alternating changes with the consumer always ready.
    s = 10'h006;
    for (int i = 1; i <= 300; i++) begin
      s[0] = ~s[0];
      set_s(s);
      step();
      if (i == 254) check("sat_cnt_254", 32'(CHANGE_CNT), 32'd254);
      if (i == 255) check("sat_cnt_255", 32'(CHANGE_CNT), 32'd255);
    end
    OUT_READY = 1'b0;
    check("sat_cnt_hold", 32'(CHANGE_CNT), 32'd255);
    check("sat_ovf", 32'(OVERFLOW), 32'd0);
    check("sat_valid", 32'(OUT_VALID), 32'd1);
    check("sat_data", 32'(OUT_DATA), 32'h006);
    check("sat_occ", 32'(dut.u_fifo.r_count), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
